// File: rtl/code_demux_v.sv
`default_nettype none
// ============================================================================
// Module      : code_demux_v
// Description : 1-to-4 code router. One offered code is delivered into one of
//               four single-entry channel buffers, using valid/ready handshakes
//               on both sides. Each channel keeps a 1-bit EMPTY/FULL state.
//               A full channel can be drained and reloaded on the same edge,
//               so back-to-back traffic to one channel has no bubble.
// Ports       : i_clk        - clock, rising edge active
//               i_rst        - asynchronous active-high reset
//               i_en         - block enable; gates accepts only
//               i_code       - code offered for routing (WIDTH bits)
//               i_valid      - i_code is valid this cycle
//               o_ready      - an offer would be accepted this cycle (comb.)
//               i_sel_code   - destination channel 0..3
//               o_code_0..3  - registered channel codes (WIDTH bits each)
//               o_valid      - bit n: o_code_n holds an undelivered code
//               i_ready      - bit n: consumer n takes o_code_n this cycle
// Options     : CODE_DEMUX_AUTO_SEL_EN - when defined, i_sel_code is ignored
//               and the destination comes from a 2-bit round-robin counter
//               that advances once per accepted code.
// Revision    : 1.0 - initial release
// ============================================================================
module code_demux_v #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_sel_code,
    output logic [WIDTH-1:0] o_code_0,
    output logic [WIDTH-1:0] o_code_1,
    output logic [WIDTH-1:0] o_code_2,
    output logic [WIDTH-1:0] o_code_3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]       r_state     [4];
    logic [0:0]       w_state_nxt [4];
    logic [WIDTH-1:0] r_code      [4];
    logic [1:0]       w_sel;
    logic             w_accept;
    logic [3:0]       w_drain;
    logic [3:0]       w_load;

    // ------------------------------------------------------------------
    // Destination select
    // ------------------------------------------------------------------
`ifdef CODE_DEMUX_AUTO_SEL_EN
    logic [1:0] r_auto_sel;

    // Only a real accept advances the counter, so a blocked offer keeps
    // waiting for the same channel. Natural 2-bit wrap gives 3 -> 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_auto_sel <= 2'd0;
        end else if (w_accept) begin
            r_auto_sel <= r_auto_sel + 2'd1;
        end
    end

    assign w_sel = r_auto_sel;
`else
    assign w_sel = i_sel_code;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The reset term keeps o_ready low while reset holds the buffers empty,
    // which would otherwise make the block look ready.
    always_comb begin
        o_ready = i_en & ~i_rst & ((r_state[w_sel] == c_EMPTY) | i_ready[w_sel]);
    end

    assign w_accept = i_valid & o_ready;

    // ------------------------------------------------------------------
    // Per-channel state machine (register / next-state / output)
    // ------------------------------------------------------------------
    generate
        for (genvar n = 0; n < 4; n++) begin : g_ch
            assign w_drain[n] = (r_state[n] == c_FULL) & i_ready[n];
            assign w_load[n]  = w_accept & (w_sel == 2'(n));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_state[n] <= c_EMPTY;
                end else begin
                    r_state[n] <= w_state_nxt[n];
                end
            end

            // A load wins over a drain: drain+accept on the same edge
            // stays FULL with the new code.
            always_comb begin
                w_state_nxt[n] = r_state[n];
                if (w_load[n]) begin
                    w_state_nxt[n] = c_FULL;
                end else if (w_drain[n]) begin
                    w_state_nxt[n] = c_EMPTY;
                end
            end

            always_comb begin
                o_valid[n] = (r_state[n] == c_FULL);
            end

            // The code register changes only on a load; a drain leaves the
            // last delivered value visible.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_code[n] <= '0;
                end else if (w_load[n]) begin
                    r_code[n] <= i_code;
                end
            end
        end
    endgenerate

    assign o_code_0 = r_code[0];
    assign o_code_1 = r_code[1];
    assign o_code_2 = r_code[2];
    assign o_code_3 = r_code[3];

endmodule
`default_nettype wire

// File: tb/tb_code_demux_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_demux_v
// Description : Self-checking bench for code_demux_v. A table of directed
//               vectors with hand-computed results covers routing, blocking,
//               same-edge drain+reload, independent drains and redirection;
//               hand-written sequences cover enable-low draining and
//               asynchronous reset. The round-robin select option has its own
//               sequence when CODE_DEMUX_AUTO_SEL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_demux_v;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] code;
    logic             valid;
    logic             ready_o;
    logic [1:0]       sel;
    logic [WIDTH-1:0] code_0, code_1, code_2, code_3;
    logic [3:0]       valid_o;
    logic [3:0]       ready_i;

    int checks = 0;
    int errors = 0;

    code_demux_v #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_code     (code),
        .i_valid    (valid),
        .o_ready    (ready_o),
        .i_sel_code (sel),
        .o_code_0   (code_0),
        .o_code_1   (code_1),
        .o_code_2   (code_2),
        .o_code_3   (code_3),
        .o_valid    (valid_o),
        .i_ready    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       valid;
        logic [1:0] sel;
        logic [7:0] code;
        logic [3:0] ready;
        logic       exp_ready;   // o_ready before the edge
        logic [3:0] exp_valid;   // o_valid after the edge
        logic [7:0] exp_c0, exp_c1, exp_c2, exp_c3;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] v,
                            input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        chk({name, ".valid"}, 32'(valid_o), 32'(v));
        chk({name, ".c0"}, 32'(code_0), 32'(c0));
        chk({name, ".c1"}, 32'(code_1), 32'(c1));
        chk({name, ".c2"}, 32'(code_2), 32'(c2));
        chk({name, ".c3"}, 32'(code_3), 32'(c3));
    endtask

    task automatic drive(input logic e, input logic v, input logic [1:0] s,
                         input logic [7:0] c, input logic [3:0] r);
        en = e; valid = v; sel = s; code = c; ready_i = r;
    endtask

    function automatic logic [7:0] chan_code(input int n);
        case (n)
            0: return code_0;
            1: return code_1;
            2: return code_2;
            default: return code_3;
        endcase
    endfunction

    initial begin
        // {en, valid, sel, code, ready, exp_ready, exp_valid, c0, c1, c2, c3}
        vecs[0]  = '{1, 1, 2, 8'hC0, 4'b0000, 1, 4'b0100, 8'h00, 8'h00, 8'hC0, 8'h00};
        vecs[1]  = '{1, 1, 1, 8'h40, 4'b0000, 1, 4'b0110, 8'h00, 8'h40, 8'hC0, 8'h00};
        vecs[2]  = '{1, 1, 1, 8'h20, 4'b0000, 0, 4'b0110, 8'h00, 8'h40, 8'hC0, 8'h00};
        vecs[3]  = '{1, 1, 1, 8'h20, 4'b0010, 1, 4'b0110, 8'h00, 8'h20, 8'hC0, 8'h00};
        vecs[4]  = '{1, 1, 0, 8'h80, 4'b0100, 1, 4'b0011, 8'h80, 8'h20, 8'hC0, 8'h00};
        vecs[5]  = '{0, 1, 3, 8'hFF, 4'b0001, 0, 4'b0010, 8'h80, 8'h20, 8'hC0, 8'h00};
        vecs[6]  = '{0, 1, 3, 8'hFF, 4'b0001, 0, 4'b0010, 8'h80, 8'h20, 8'hC0, 8'h00};
        vecs[7]  = '{1, 0, 3, 8'h11, 4'b0000, 1, 4'b0010, 8'h80, 8'h20, 8'hC0, 8'h00};
        vecs[8]  = '{1, 1, 1, 8'h33, 4'b0000, 0, 4'b0010, 8'h80, 8'h20, 8'hC0, 8'h00};
        vecs[9]  = '{1, 1, 3, 8'h33, 4'b0000, 1, 4'b1010, 8'h80, 8'h20, 8'hC0, 8'h33};
        vecs[10] = '{1, 1, 3, 8'h44, 4'b1010, 1, 4'b1000, 8'h80, 8'h20, 8'hC0, 8'h44};
        vecs[11] = '{1, 0, 0, 8'h00, 4'b1000, 1, 4'b0000, 8'h80, 8'h20, 8'hC0, 8'h44};

        rst = 1'b1;
        drive(1, 1, 0, 8'h5A, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 32'(ready_o), 32'd0);
        chk_outs("reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        @(negedge clk);
        rst = 1'b0;

`ifdef CODE_DEMUX_AUTO_SEL_EN
        // Round-robin: channel comes from the counter whatever sel says.
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 2'(3 - (k % 4)), 8'(k + 1), 4'b1111);
            #1;
            chk($sformatf("auto%0d.ready", k), 32'(ready_o), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("auto%0d.valid", k), 32'(valid_o), 32'(4'b0001 << (k % 4)));
            chk($sformatf("auto%0d.code", k), 32'(chan_code(k % 4)), 32'(k + 1));
            @(negedge clk);
        end
`else
        // First accept is possible on the first edge after reset release.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].sel, vecs[i].code, vecs[i].ready);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].exp_valid,
                     vecs[i].exp_c0, vecs[i].exp_c1, vecs[i].exp_c2, vecs[i].exp_c3);
            @(negedge clk);
        end

        // Enable low: held code in channel 0 drains, nothing is accepted.
        drive(1, 1, 0, 8'h80, 4'b0000);
        @(posedge clk);
        #1;
        chk("en.fill", 32'(valid_o), 32'(4'b0001));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 2'(k % 4), 8'hE0 + 8'(k), 4'b0001);
            #1;
            chk($sformatf("en%0d.ready", k), 32'(ready_o), 32'd0);
            @(posedge clk);
            #1;
            chk_outs($sformatf("en%0d", k), 4'b0000, 8'h80, 8'h20, 8'hC0, 8'h44);
            @(negedge clk);
        end

        // Fill all four channels, then reset between edges.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 2'(k), 8'hA1 + 8'(k), 4'b0000);
            @(posedge clk);
            @(negedge clk);
        end
        drive(1, 0, 0, 8'h00, 4'b0000);
        #1;
        chk_outs("full", 4'b1111, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.ready", 32'(ready_o), 32'd0);
        chk_outs("arst", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 3, 8'h5C, 4'b0000);
        #1;
        chk("post.ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        chk_outs("post", 4'b1000, 8'h00, 8'h00, 8'h00, 8'h5C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_demux_v.md
CODE_DEMUX_V -- requirements
Module: code_demux_v

Interface
REQ-001 Parameter WIDTH, default 8, code width in bits for the input and all four output channels.
REQ-002 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_en  input  1  block enable; when low, no code is accepted.
REQ-005 i_code  input  WIDTH  code offered for routing.
REQ-006 i_valid  input  1  i_code is valid this cycle.
REQ-007 o_ready  output  1  block can accept i_code this cycle (combinational).
REQ-008 i_sel_code  input  2  destination channel select, 0..3.
REQ-009 o_code_0 .. o_code_3  output  WIDTH each  registered channel codes.
REQ-010 o_valid  output  4  bit n: o_code_n holds an undelivered code.
REQ-011 i_ready  input  4  bit n: consumer n takes o_code_n this cycle.

Function
REQ-012 The block SHALL act as the 1-to-4 routing counterpart of the 4-to-1 code selector: one input code is delivered to one of four single-entry channel buffers.
REQ-013 The effective select SHALL be sel = i_sel_code, except as modified by REQ-030.
REQ-014 The block SHALL drive o_ready = i_en & (~o_valid[sel] | i_ready[sel]).
REQ-015 An accept SHALL occur on a rising edge where i_valid & o_ready = 1.
REQ-016 On an accept, o_code_sel SHALL load i_code and o_valid[sel] SHALL be 1 after that edge, giving 1-cycle latency.
REQ-017 A drain SHALL occur on channel n at a rising edge where o_valid[n] & i_ready[n] = 1; after that edge o_valid[n] SHALL be 0 unless REQ-018 applies.
REQ-018 A simultaneous drain and accept on the same channel SHALL load the new code and keep o_valid[n] = 1 with no bubble.
REQ-019 Drains on non-selected channels SHALL proceed independently in the same cycle as an accept.
REQ-020 o_code_n SHALL change only on an accept to channel n or on reset; after a drain it SHALL keep its last value.
REQ-021 i_ready[n] while o_valid[n] = 0 SHALL have no effect.
REQ-022 i_en low SHALL block accepts only; buffered codes SHALL remain drainable.
REQ-023 A change of i_sel_code while i_valid is high and o_ready is low SHALL redirect the pending offer; no code is duplicated or lost.
REQ-024 The block SHALL maintain a per-channel 1-bit state (EMPTY, FULL): EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with accept, or when idle.

Reset
REQ-025 Assertion of i_rst SHALL take effect immediately, independent of i_clk.
REQ-026 While i_rst is high: o_valid = 4'b0000, o_code_0..3 = 0, and the auto-select counter = 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered codes, with no drain reported.
REQ-028 o_ready SHALL be 0 while i_rst is high.
REQ-029 The first accept SHALL be possible on the first rising edge after i_rst deasserts.

Configuration
REQ-030 With macro CODE_DEMUX_AUTO_SEL_EN defined, i_sel_code SHALL be ignored; sel SHALL come from an internal 2-bit counter that resets to 0, increments by 1 after each accept, and wraps from 3 to 0. A blocked offer SHALL not advance the counter.
REQ-031 Without CODE_DEMUX_AUTO_SEL_EN, the counter SHALL NOT exist and sel SHALL equal i_sel_code.

Verification
REQ-032 Reset, then i_en=1, i_valid=1, i_sel_code=2, i_code=8'hC0 for one edge -> o_valid=4'b0100 and o_code_2=8'hC0 one cycle later; all other o_code_n = 0.
REQ-033 Fill channel 1 with 8'h40 and hold i_ready=0, then offer 8'h20 to channel 1 -> o_ready=0 and o_code_1 stays 8'h40; raise i_ready[1] -> same edge loads 8'h20 and o_valid[1] stays 1.
REQ-034 i_en=0, i_valid=1 for 5 cycles while channel 0 holds 8'h80 and i_ready[0]=1 -> channel 0 drains (o_valid[0]=0, o_code_0 still 8'h80) and nothing is accepted.
REQ-035 With channels 0..3 full, assert i_rst between clock edges -> o_valid=0 and all o_code_n=0 immediately, before the next edge.
REQ-036 With CODE_DEMUX_AUTO_SEL_EN defined, offer 8'h01..8'h05 back-to-back with i_ready=4'b1111 -> the codes land on channels 0,1,2,3,0 in that order and i_sel_code has no effect.
